// File: rtl/modexp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : modexp_pkg
//  Description : Shared types and constants for the modular-exponentiation
//                sequencer (state encoding, default widths, unit operand).
//  Revision    : 1.0 - initial release
// ============================================================================
package modexp_pkg;

    localparam int W_DEF  = 512;   // operand / modulus width
    localparam int EW_DEF = 512;   // maximum exponent width
    localparam int LW_DEF = 10;    // exponent-length field width (2^LW > EW)

    // Constant multiplicand used to leave the Montgomery domain
    localparam logic [W_DEF-1:0] ONE_W = {{(W_DEF-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TOX   = 3'd1,
        S_SQ    = 3'd2,
        S_MUL   = 3'd3,
        S_FROMM = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    // States that own one multiplier operation
    function automatic logic is_mm_state(input state_t s);
        return (s == S_TOX) || (s == S_SQ) || (s == S_MUL) || (s == S_FROMM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/modexp_bitscan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : modexp_bitscan
//  Description : Holds the latched exponent and its effective length, and
//                walks the bit index from the MSB down to bit 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module modexp_bitscan
    import modexp_pkg::*;
#(
    parameter int EW = EW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_load,      // accepted start: capture exponent
    input  logic [EW-1:0] i_e,
    input  logic [LW-1:0] i_len,
    input  logic          i_arm,       // point index at the top significant bit
    input  logic          i_dec,       // advance to the next lower bit
    output logic          o_cur_bit,
    output logic          o_last_bit,
    output logic          o_len_zero
);

    localparam logic [LW-1:0] c_EW_LEN  = LW'(EW);
    localparam logic [LW-1:0] c_LEN_ONE = {{(LW-1){1'b0}}, 1'b1};

    logic [EW-1:0] r_e;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_idx;
    logic          w_cur;

    // Capture exponent and its length; lengths beyond EW are clamped
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_e   <= '0;
            r_len <= '0;
        end else if (i_load) begin
            r_e   <= i_e;
            r_len <= (i_len > c_EW_LEN) ? c_EW_LEN : i_len;
        end
    end

    // Bit index: armed to len-1, then counts down one bit per step
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_idx <= '0;
        end else if (i_arm) begin
            r_idx <= r_len - c_LEN_ONE;
        end else if (i_dec) begin
            r_idx <= r_idx - c_LEN_ONE;
        end
    end

    // Select the exponent bit under the index
    always_comb begin
        w_cur = 1'b0;
        for (int i = 0; i < EW; i++) begin
            if (r_idx == LW'(i)) begin
                w_cur = r_e[i];
            end
        end
    end

    assign o_cur_bit  = w_cur;
    assign o_last_bit = (r_idx == '0);
    assign o_len_zero = (r_len == '0);

endmodule
`default_nettype wire

// File: rtl/modexp_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : modexp_ctrl
//  Description : Left-to-right square-and-multiply sequencer computing
//                x^e mod m on an external Montgomery multiplier.
//                Optional build macro MODEXP_CONST_TIME_EN: multiply step is
//                issued for every exponent bit (result discarded for zero
//                bits) and a 'dummy' output flags the discarded multiplies.
//  Revision    : 1.0 - initial release
// ============================================================================
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int EW = EW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [W-1:0]  in_x,
    input  logic [EW-1:0] in_e,
    input  logic [LW-1:0] in_e_len,
    input  logic [W-1:0]  in_m,
    input  logic [W-1:0]  in_r,
    input  logic [W-1:0]  in_r2,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          mm_start,
    output logic [W-1:0]  mm_a,
    output logic [W-1:0]  mm_b,
    output logic [W-1:0]  mm_m,
    input  logic [W-1:0]  mm_result,
    input  logic          mm_done
`ifdef MODEXP_CONST_TIME_EN
    ,
    output logic          dummy
`endif
);

    localparam logic [W-1:0] c_ONE = W'(ONE_W);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_mm_start;
    logic [W-1:0] r_mm_a;
    logic [W-1:0] r_mm_b;
    logic [W-1:0] r_m;
    logic [W-1:0] r_r;
    logic [W-1:0] r_acc;
    logic [W-1:0] r_xt;
    logic [W-1:0] r_result;

    logic         w_accept;
    logic         w_wait;
    logic         w_fire;
    logic         w_enter;
    logic         w_arm;
    logic         w_dec;
    logic         w_take_mul;
    logic         w_discard;
    logic         w_cur_bit;
    logic         w_last_bit;
    logic         w_len_zero;
    logic [W-1:0] w_acc_d;
    logic [W-1:0] w_a_d;
    logic [W-1:0] w_b_d;

    modexp_bitscan #(
        .EW (EW),
        .LW (LW)
    ) u_bitscan (
        .clk        (clk),
        .resetn     (resetn),
        .i_load     (w_accept),
        .i_e        (in_e),
        .i_len      (in_e_len),
        .i_arm      (w_arm),
        .i_dec      (w_dec),
        .o_cur_bit  (w_cur_bit),
        .o_last_bit (w_last_bit),
        .o_len_zero (w_len_zero)
    );

    // The issue cycle is the first cycle of an operation state; a completion
    // pulse is only honoured after it, so a same-cycle mm_done is dropped.
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_wait   = is_mm_state(r_state) && !r_mm_start;
    assign w_fire   = w_wait && mm_done;

`ifdef MODEXP_CONST_TIME_EN
    assign w_take_mul = 1'b1;
    assign w_discard  = (r_state == S_MUL) && !w_cur_bit;
    assign dummy      = w_discard;
`else
    assign w_take_mul = w_cur_bit;
    assign w_discard  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: square every bit, multiply on set bits, then leave the domain
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_TOX;
            S_TOX:   if (w_fire) w_state_nxt = w_len_zero ? S_FROMM : S_SQ;
            S_SQ: begin
                if (w_fire) begin
                    if (w_take_mul)      w_state_nxt = S_MUL;
                    else if (w_last_bit) w_state_nxt = S_FROMM;
                    else                 w_state_nxt = S_SQ;
                end
            end
            S_MUL:   if (w_fire) w_state_nxt = w_last_bit ? S_FROMM : S_SQ;
            S_FROMM: if (w_fire) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs and datapath controls; operands for the next operation are
    // built from the accumulator value being written on the same edge
    always_comb begin
        busy    = is_mm_state(r_state);
        done    = (r_state == S_FIN);
        w_enter = is_mm_state(w_state_nxt) && (w_accept || w_fire);
        w_arm   = (r_state == S_TOX) && w_fire;
        w_dec   = w_fire &&
                  (((r_state == S_SQ) && !w_take_mul && !w_last_bit) ||
                   ((r_state == S_MUL) && !w_last_bit));

        w_acc_d = r_acc;
        if (w_arm) begin
            w_acc_d = r_r;
        end else if (w_fire && ((r_state == S_SQ) || (r_state == S_MUL)) && !w_discard) begin
            w_acc_d = mm_result;
        end

        w_a_d = r_mm_a;
        w_b_d = r_mm_b;
        case (w_state_nxt)
            S_TOX: begin
                // mm_a/mm_b double as the latched x and R^2 for this step
                w_a_d = in_x;
                w_b_d = in_r2;
            end
            S_SQ: begin
                w_a_d = w_acc_d;
                w_b_d = w_acc_d;
            end
            S_MUL: begin
                w_a_d = w_acc_d;
                w_b_d = r_xt;
            end
            S_FROMM: begin
                w_a_d = w_acc_d;
                w_b_d = c_ONE;
            end
            default: begin
                w_a_d = r_mm_a;
                w_b_d = r_mm_b;
            end
        endcase
    end

    // Multiplier launch: one pulse per operation, operands held until done
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mm_start <= 1'b0;
            r_mm_a     <= '0;
            r_mm_b     <= '0;
        end else begin
            r_mm_start <= w_enter;
            if (w_enter) begin
                r_mm_a <= w_a_d;
                r_mm_b <= w_b_d;
            end
        end
    end

    // Operand latch on accepted start, accumulator and result capture
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_m      <= '0;
            r_r      <= '0;
            r_acc    <= '0;
            r_xt     <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_m <= in_m;
                r_r <= in_r;
            end
            r_acc <= w_acc_d;
            if (w_arm) begin
                r_xt <= mm_result;
            end
            if ((r_state == S_FROMM) && w_fire) begin
                r_result <= mm_result;
            end
        end
    end

    assign mm_start = r_mm_start;
    assign mm_a     = r_mm_a;
    assign mm_b     = r_mm_b;
    assign mm_m     = r_m;
    assign result   = r_result;

endmodule
`default_nettype wire

// File: tb/tb_modexp_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_modexp_ctrl
//  Description : Self-checking bench for modexp_ctrl with a behavioural
//                Montgomery multiplier (fixed 5-cycle latency) and a
//                result scoreboard fed by an independent modpow reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modexp_ctrl;

    localparam int W      = 512;
    localparam int EW     = 512;
    localparam int LW     = 10;
    localparam int MM_LAT = 5;
    localparam int LIMIT  = 20000;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [W-1:0]  in_x;
    logic [EW-1:0] in_e;
    logic [LW-1:0] in_e_len;
    logic [W-1:0]  in_m;
    logic [W-1:0]  in_r;
    logic [W-1:0]  in_r2;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          mm_start;
    logic [W-1:0]  mm_a;
    logic [W-1:0]  mm_b;
    logic [W-1:0]  mm_m;
    logic [W-1:0]  mm_result;
    logic          mm_done;
`ifdef MODEXP_CONST_TIME_EN
    logic          dummy;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int n_mm    = 0;
    int n_dummy = 0;
    int n_viol  = 0;
    int n_done  = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    modexp_ctrl #(
        .W  (W),
        .EW (EW),
        .LW (LW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .in_x      (in_x),
        .in_e      (in_e),
        .in_e_len  (in_e_len),
        .in_m      (in_m),
        .in_r      (in_r),
        .in_r2     (in_r2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_m      (mm_m),
        .mm_result (mm_result),
        .mm_done   (mm_done)
`ifdef MODEXP_CONST_TIME_EN
        ,
        .dummy     (dummy)
`endif
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Montgomery product a*b*2^-W mod m, bit-serial
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
        logic [W+1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] modmul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
        logic [2*W-1:0] p;
        p = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, m};
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] r_of(input logic [W-1:0] m);
        logic [W:0] big;
        big    = '0;
        big[W] = 1'b1;
        big    = big % {1'b0, m};
        return big[W-1:0];
    endfunction

    function automatic logic [W-1:0] modpow(input logic [W-1:0] x, input logic [EW-1:0] e,
                                            input int len, input logic [W-1:0] m);
        logic [W-1:0] acc;
        acc = W'(1);
        for (int i = len - 1; i >= 0; i--) begin
            acc = modmul(acc, acc, m);
            if (e[i]) acc = modmul(acc, x, m);
        end
        return acc;
    endfunction

    function automatic int mm_expect(input logic [EW-1:0] e, input int len);
        int n;
        n = 2 + len;
`ifdef MODEXP_CONST_TIME_EN
        n = n + len;
`else
        for (int i = 0; i < len; i++) if (e[i]) n++;
`endif
        return n;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Behavioural multiplier; also counts launches and operand instability
    logic [W-1:0] cap_a, cap_b, cap_m;
    int           mm_cd = 0;
    bit           mm_pend = 1'b0;
    initial begin
        mm_done   = 1'b0;
        mm_result = '0;
    end
    always @(negedge clk) begin
        mm_done = 1'b0;
        if (!resetn) begin
            mm_pend = 1'b0;
        end else begin
            if (mm_pend) begin
                if (mm_a !== cap_a || mm_b !== cap_b) n_viol++;
                mm_cd--;
                if (mm_cd == 0) begin
                    mm_result = mont(cap_a, cap_b, cap_m);
                    mm_done   = 1'b1;
                    mm_pend   = 1'b0;
                end
            end
            if (mm_start) begin
                if (mm_pend) n_viol++;
                mm_pend = 1'b1;
                mm_cd   = MM_LAT;
                cap_a   = mm_a;
                cap_b   = mm_b;
                cap_m   = mm_m;
                n_mm++;
`ifdef MODEXP_CONST_TIME_EN
                if (dummy) n_dummy++;
`endif
            end
        end
    end

    // Scoreboard: every done pops one expected result
    always @(negedge clk) begin
        if (resetn && done) begin
            n_done++;
            chk("busy_at_done", W'(busy), W'(0));
            if (exp_q.size() == 0) begin
                chk("unexpected_done", W'(1), W'(0));
            end else begin
                chk("result", result, exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [EW-1:0] e,
                          input logic [LW-1:0] len, input logic [W-1:0] m, input int poke,
                          output int cycles, output int dummies);
        logic [W-1:0] r;
        int mm0, d0, v0, dn0, eff_len, exp_cnt;
        r       = r_of(m);
        eff_len = (int'(len) > EW) ? EW : int'(len);
        exp_q.push_back(modpow(x, e, eff_len, m));
        exp_cnt = mm_expect(e, eff_len);
        mm0 = n_mm;
        d0  = n_dummy;
        v0  = n_viol;
        dn0 = n_done;
        @(posedge clk); #1;
        in_x     = x;
        in_e     = e;
        in_e_len = len;
        in_m     = m;
        in_r     = r;
        in_r2    = modmul(r, r, m);
        start    = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 1;
        while (n_done == dn0 && cycles < LIMIT) begin
            if (cycles == poke) begin
                in_x  = ~x;
                in_e  = ~e;
                in_m  = m ^ W'(2);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        if (n_done == dn0) begin
            chk({tag, "_timeout"}, W'(0), W'(1));
            $display("test done: total=%0d bad=%0d", n_total, n_bad);
            $finish;
        end
        chk({tag, "_mm_count"}, W'(n_mm - mm0), W'(exp_cnt));
        chk({tag, "_done_width"}, W'(done), W'(0));
        chk({tag, "_busy_after"}, W'(busy), W'(0));
        chk({tag, "_stable"}, W'(n_viol - v0), W'(0));
        dummies = n_dummy - d0;
    endtask

    initial begin
        int cyc, dum, cyc_b, dum_b, mm0, dn0;
        logic [W-1:0]  m, x, r;
        logic [EW-1:0] e;

        resetn   = 1'b0;
        start    = 1'b0;
        in_x     = '0;
        in_e     = '0;
        in_e_len = '0;
        in_m     = '0;
        in_r     = '0;
        in_r2    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_result", result, W'(0));
        chk("rst_mm_start", W'(mm_start), W'(0));
        chk("rst_mm_a", mm_a, W'(0));
        chk("rst_mm_b", mm_b, W'(0));
        @(posedge clk); #1;
        resetn = 1'b1;

        run_op("basic", W'(5), EW'(3), LW'(2), W'(13), -1, cyc, dum);
        run_op("zero_exp", W'(7), EW'(0), LW'(0), W'(13), -1, cyc, dum);
        run_op("high_bits", W'(5), EW'(243), LW'(2), W'(13), -1, cyc, dum);
        run_op("restart_busy", W'(6), EW'(11), LW'(4), W'(13), 15, cyc, dum);
        run_op("after_restart", W'(3), EW'(5), LW'(3), W'(11), -1, cyc, dum);

        // Abort a run during its first square
        r   = r_of(W'(13));
        mm0 = n_mm;
        dn0 = n_done;
        @(posedge clk); #1;
        in_x     = W'(5);
        in_e     = EW'(45);
        in_e_len = LW'(6);
        in_m     = W'(13);
        in_r     = r;
        in_r2    = modmul(r, r, W'(13));
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while ((n_mm - mm0) < 2 && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_reach_sq", W'(n_mm - mm0), W'(2));
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_done", W'(done), W'(0));
        chk("abort_mm_start", W'(mm_start), W'(0));
        chk("abort_mm_a", mm_a, W'(0));
        chk("abort_mm_b", mm_b, W'(0));
        chk("abort_result", result, W'(0));
        resetn = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("abort_no_done", W'(n_done - dn0), W'(0));
        chk("abort_idle", W'(busy), W'(0));
        run_op("after_abort", W'(9), EW'(45), LW'(6), W'(13), -1, cyc, dum);

        // Length beyond EW is clamped to EW
        m      = rand_w();
        m[0]   = 1'b1;
        m[W-1] = 1'b1;
        x      = rand_w() % m;
        run_op("clamp", x, EW'(3), LW'(700), m, -1, cyc, dum);

        for (int it = 0; it < 8; it++) begin
            m      = rand_w();
            m[0]   = 1'b1;
            m[W-1] = 1'b1;
            x      = rand_w() % m;
            e      = rand_w();
            run_op("rand512", x, e, LW'(512), m, -1, cyc, dum);
        end

`ifdef MODEXP_CONST_TIME_EN
        run_op("ct_sparse", W'(5), EW'(8), LW'(4), W'(13), -1, cyc, dum);
        run_op("ct_dense", W'(5), EW'(15), LW'(4), W'(13), -1, cyc_b, dum_b);
        chk("ct_cycles_equal", W'(cyc), W'(cyc_b));
        chk("ct_dummy_sparse", W'(dum), W'(3));
        chk("ct_dummy_dense", W'(dum_b), W'(0));
`else
        cyc_b = 0;
        dum_b = 0;
`endif

        repeat (5) @(posedge clk);
        chk("queue_drained", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
